// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester shared-multiply arbiter.
package mult_arb_pkg;

    localparam int unsigned WidthDefault   = 32;
    localparam int unsigned TimeoutDefault = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp,
        StGap
    } state_e;

endpackage

// File: rtl/mult_arb_if.sv
// Request/response and shared-multiply signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mult_arb_if
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
);

    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_op1;
    logic [WIDTH-1:0]   req0_op2;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_op1;
    logic [WIDTH-1:0]   req1_op2;

    logic               resp0_valid;
    logic               resp0_ready;
    logic [2*WIDTH-1:0] resp0_product;
    logic               resp0_err;
    logic               resp1_valid;
    logic               resp1_ready;
    logic [2*WIDTH-1:0] resp1_product;
    logic               resp1_err;

    logic               mult_begin;
    logic [WIDTH-1:0]   mult_op1;
    logic [WIDTH-1:0]   mult_op2;
    logic [2*WIDTH-1:0] product;
    logic               mult_end;

    logic               busy;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req1_valid, req1_op1, req1_op2,
        input  resp0_ready, resp1_ready, product, mult_end,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_product, resp0_err,
        output resp1_valid, resp1_product, resp1_err,
        output mult_begin, mult_op1, mult_op2, busy
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req1_valid, req1_op1, req1_op2,
        output resp0_ready, resp1_ready, product, mult_end,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_product, resp0_err,
        input  resp1_valid, resp1_product, resp1_err,
        input  mult_begin, mult_op1, mult_op2, busy
    );

endinterface

// File: rtl/mult_arb_rr.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// Priority points at requester 0 out of reset.
module mult_arb_rr (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    assign prio_d = update_i ? ~served_i : prio_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiply unit between two requesters: accept, run with a watchdog,
// hold the owner's response until consumed, then drop mult_begin for one cycle.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH          = WidthDefault,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
    input logic       clk,
    input logic       resetn,
    mult_arb_if.slave bus
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic               owner_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    logic               mbegin_q;
    logic [CntW-1:0]    wd_q;
    logic [2*WIDTH-1:0] res0_q;
    logic [2*WIDTH-1:0] res1_q;
    logic [1:0]         err_q;
    logic [1:0]         rvalid_q;

    logic [1:0]         req;
    logic [1:0]         gnt;
    logic [1:0]         ready;
    logic [1:0]         hs;
    logic               in_idle;
    logic               resp_hs;
    logic               run_done;
    logic [2*WIDTH-1:0] done_prod;

    assign req      = {bus.req1_valid, bus.req0_valid};
    assign in_idle  = (state_q == StIdle);
    assign ready    = gnt & {2{in_idle}};
    assign hs       = ready & req;
    assign resp_hs  = owner_q ? (rvalid_q[1] & bus.resp1_ready)
                              : (rvalid_q[0] & bus.resp0_ready);
    // A completion on the last watchdog cycle still counts as a good result.
    assign run_done  = bus.mult_end || (wd_q == WdLast);
    assign done_prod = bus.mult_end ? bus.product : '0;

    mult_arb_rr u_rr (
        .clk      (clk),
        .resetn   (resetn),
        .req_i    (req),
        .update_i (state_q == StGap),
        .served_i (owner_q),
        .gnt_o    (gnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            mbegin_q <= 1'b0;
            wd_q     <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            err_q    <= '0;
            rvalid_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|hs) begin
                        owner_q  <= hs[1];
                        op1_q    <= hs[1] ? bus.req1_op1 : bus.req0_op1;
                        op2_q    <= hs[1] ? bus.req1_op2 : bus.req0_op2;
                        mbegin_q <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (run_done) begin
                        mbegin_q          <= 1'b0;
                        wd_q              <= '0;
                        rvalid_q[owner_q] <= 1'b1;
                        err_q[owner_q]    <= ~bus.mult_end;
                        if (owner_q) begin
                            res1_q <= done_prod;
                        end else begin
                            res0_q <= done_prod;
                        end
                        state_q <= StResp;
                    end else begin
                        wd_q <= wd_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (resp_hs) begin
                        rvalid_q <= '0;
                        err_q    <= '0;
                        res0_q   <= '0;
                        res1_q   <= '0;
                        state_q  <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req0_ready    = ready[0];
    assign bus.req1_ready    = ready[1];
    assign bus.resp0_valid   = rvalid_q[0];
    assign bus.resp0_product = res0_q;
    assign bus.resp0_err     = err_q[0];
    assign bus.resp1_valid   = rvalid_q[1];
    assign bus.resp1_product = res1_q;
    assign bus.resp1_err     = err_q[1];
    assign bus.mult_begin    = mbegin_q;
    assign bus.mult_op1      = op1_q;
    assign bus.mult_op2      = op2_q;
    assign bus.busy          = !in_idle;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: signed multiply model with a never-finishing stub mode,
// table-driven single requests plus arbitration, back-pressure, timeout and reset sequences.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int unsigned W      = 32;
    localparam int unsigned Tmo    = TimeoutDefault;
    localparam int unsigned MulLat = 3;

    typedef struct {
        int          id;
        logic [63:0] prod;
        logic        err;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mult_arb_if #(.WIDTH(W)) bus ();

    mult_arbiter #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Multiply model: signed product, mult_end after MulLat cycles of mult_begin.
    bit          stub = 1'b0;
    int unsigned mcnt = 0;
    always @(posedge clk) begin
        if (!bus.mult_begin) mcnt <= 0;
        else if (mcnt != MulLat) mcnt <= mcnt + 1;
    end
    assign bus.mult_end = bus.mult_begin && (mcnt == MulLat) && !stub;
    assign bus.product  = $signed(bus.mult_op1) * $signed(bus.mult_op2);

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input int id, input logic [63:0] p, input logic e);
        exp_t x;
        x.id = id;
        x.prod = p;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic score(input int id, input logic [63:0] p, input logic e);
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: resp%0d product %h err %0b, want no response", id, p, e);
            return;
        end
        x = sb.pop_front();
        check("resp_id", 64'(id), 64'(x.id));
        check("resp_product", p, x.prod);
        check("resp_err", 64'(e), 64'(x.err));
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.resp0_valid && bus.resp0_ready) score(0, bus.resp0_product, bus.resp0_err);
            if (bus.resp1_valid && bus.resp1_ready) score(1, bus.resp1_product, bus.resp1_err);
            if (bus.resp0_valid && bus.resp1_valid) check("one_owner", 64'd1, 64'd0);
        end
    end

    task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_op1 = a;
            bus.req0_op2 = b;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_op1 = a;
            bus.req1_op2 = b;
        end
    endtask

    // Waits for the grant, checks the other ready is low, returns just after the handshake edge.
    task automatic accept(input int id);
        int n;
        bit rdy;
        bit other;
        n = 0;
        rdy = 1'b0;
        other = 1'b0;
        while (!rdy && n < 300) begin
            @(negedge clk);
            rdy   = (id == 0) ? bus.req0_ready : bus.req1_ready;
            other = (id == 0) ? bus.req1_ready : bus.req0_ready;
            n++;
        end
        check("accept_grant", 64'(rdy), 64'd1);
        check("accept_other_ready", 64'(other), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(sb.size() == 0 && !bus.busy), 64'd1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang, want completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        bit seen;

        vecs[0] = '{1, 32'd3,          32'd5,          64'd15};
        vecs[1] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
        vecs[2] = '{1, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001};
        vecs[3] = '{0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[4] = '{1, 32'd0,          32'h1234_5678,  64'd0};
        vecs[5] = '{0, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};
        vecs[6] = '{1, 32'hFFFF_FFFE,  32'd7,          64'hFFFF_FFFF_FFFF_FFF2};

        bus.req0_valid = 0; bus.req0_op1 = 0; bus.req0_op2 = 0;
        bus.req1_valid = 0; bus.req1_op1 = 0; bus.req1_op2 = 0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        resetn = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_mult_begin", 64'(bus.mult_begin), 64'd0);
        check("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
        check("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
        check("rst_mult_op1", 64'(bus.mult_op1), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 64'(bus.req0_ready | bus.req1_ready), 64'd0);

        // Signed product, latency and the mult_begin gap.
        @(posedge clk); #1;
        expect_resp(0, 64'hFFFF_FFFF_E000_0000, 1'b0);
        drive(0, 32'hF000_0000, 32'h0000_0002);
        accept(0);
        bus.req0_valid = 0;
        @(negedge clk);
        check("begin_after_hs", 64'(bus.mult_begin), 64'd1);
        n = 0;
        while (!bus.resp0_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", 64'(n), 64'(MulLat + 1));
        check("resp_begin_low", 64'(bus.mult_begin), 64'd0);
        @(negedge clk);
        check("gap_begin_low", 64'(bus.mult_begin), 64'd0);
        check("gap_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("idle_not_busy", 64'(bus.busy), 64'd0);

        foreach (vecs[i]) begin
            expect_resp(vecs[i].id, vecs[i].p, 1'b0);
            @(posedge clk); #1;
            drive(vecs[i].id, vecs[i].a, vecs[i].b);
            accept(vecs[i].id);
            if (vecs[i].id == 0) bus.req0_valid = 0;
            else bus.req1_valid = 0;
            wait_done("vec_done");
        end

        // Simultaneous requests after reset; a re-raised req0 then loses to pending req1.
        do_reset();
        expect_resp(0, 64'd15, 1'b0);
        expect_resp(1, 64'd63, 1'b0);
        expect_resp(0, 64'd143, 1'b0);
        @(posedge clk); #1;
        drive(0, 32'd3, 32'd5);
        drive(1, 32'd7, 32'd9);
        accept(0);
        drive(0, 32'd11, 32'd13);
        accept(1);
        bus.req1_valid = 0;
        accept(0);
        bus.req0_valid = 0;
        wait_done("rr_done");

        // Response back-pressure with another request waiting.
        expect_resp(0, 64'h0001_2340, 1'b0);
        expect_resp(1, 64'd6, 1'b0);
        bus.resp0_ready = 0;
        @(posedge clk); #1;
        drive(0, 32'h1234, 32'h10);
        accept(0);
        bus.req0_valid = 0;
        drive(1, 32'd2, 32'd3);
        n = 0;
        while (!bus.resp0_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.resp0_valid), 64'd1);
            check("hold_product", bus.resp0_product, 64'h0001_2340);
            check("hold_req1_ready", 64'(bus.req1_ready), 64'd0);
            check("hold_busy", 64'(bus.busy), 64'd1);
            check("hold_resp1_idle", 64'(bus.resp1_valid), 64'd0);
        end
        @(posedge clk); #1;
        bus.resp0_ready = 1;
        accept(1);
        bus.req1_valid = 0;
        wait_done("hold_done");

        // Watchdog timeout with a multiply that never finishes.
        stub = 1'b1;
        expect_resp(0, 64'd0, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'd5, 32'd6);
        accept(0);
        bus.req0_valid = 0;
        @(negedge clk);
        check("tmo_begin", 64'(bus.mult_begin), 64'd1);
        n = 0;
        while (!bus.resp0_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", 64'(n), 64'(Tmo));
        wait_done("tmo_done");
        stub = 1'b0;

        // Reset mid-RUN drops the transaction.
        @(posedge clk); #1;
        drive(0, 32'd6, 32'd7);
        accept(0);
        bus.req0_valid = 0;
        @(negedge clk);
        check("mid_run_begin", 64'(bus.mult_begin), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_mult_begin", 64'(bus.mult_begin), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_op1", 64'(bus.mult_op1), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp0_valid || bus.resp1_valid || bus.busy) seen = 1'b1;
        end
        check("arst_no_resp", 64'(seen), 64'd0);
        expect_resp(0, 64'd42, 1'b0);
        @(posedge clk); #1;
        drive(0, 32'd6, 32'd7);
        accept(0);
        bus.req0_valid = 0;
        wait_done("post_rst_done");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
